mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares one single-ported AW x DW register array among NREQ requesters.
- The array is the 128 x 8 reg-array style storage used beside the 8-bit bus in the mixed-module designs.
- Sits between requester blocks and the array.
- Each requester presents a read or write request and receives a grant, a one-cycle ack and, for reads, the returned data.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 7, address width; array depth is 2**AW = 128.
- DW, 8, data width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rstb  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level.
- we  input  NREQ  per-requester write flag (1 = write, 0 = read).
- addr  input  NREQ*AW  flattened addresses; requester k at [k*AW +: AW].
- wdata  input  NREQ*DW  flattened write data; requester k at [k*DW +: DW].
- lock  input  NREQ  per-requester grant-lock request (see Optional Feature).
- gnt  output  NREQ  one-hot grant, held for the whole transaction.
- ack  output  NREQ  one-hot, one-cycle transaction-complete pulse.
- rdata  output  DW  read data, valid while ack is high for a read.
- busy  output  1  high whenever state != IDLE.
- mem_en  output  1  array access strobe.
- mem_we  output  1  array write enable.
- mem_addr  output  AW  array address.
- mem_wdata  output  DW  array write data.
- mem_rdata  input  DW  array read data, valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Reset: all of the following are 0: gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata. State = IDLE. Round-robin pointer last = NREQ-1, so requester 0 has first priority. Reset takes effect immediately, including mid-transaction; no ack is issued for an aborted access.
- FSM states: IDLE, ISSUE, RESP, ACK. All outputs are registered.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the first set req bit searching last+1, last+2, ... with wrap modulo NREQ.
  - Register sel, set last = sel, gnt = 1<<sel, go to ISSUE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we = we[sel]; mem_addr = addr[sel]; mem_wdata = wdata[sel].
  - Fields are sampled at the IDLE->ISSUE edge.
  - Go to RESP.
- RESP (1 cycle):
  - mem_en = 0.
  - For a read, mem_rdata is captured into rdata at the end of this cycle.
  - For a write, rdata keeps its previous value.
  - Go to ACK.
- ACK (1 cycle):
  - ack[sel] = 1; gnt is still asserted.
  - Next state is IDLE, with gnt cleared, unless the lock continuation applies (Optional Feature).
- Timing: a request sampled in IDLE at edge T gives mem_en in cycle T+1, ack in cycle T+3 and gnt low in cycle T+4. Throughput is one transaction per 4 cycles.
- Requesters hold req, we, addr and wdata stable until ack. If req drops after the grant, the transaction still completes and ack still pulses.
- A requester whose req is still high after its ack competes normally. The pointer has moved past it, so other pending requesters win first.
- Simultaneous requests: exactly one grant per transaction, with strict rotation. With all NREQ requesting continuously, grants cycle 0,1,2,...,NREQ-1,0.
- gnt and ack are always one-hot or zero, never multi-hot.
- Addresses and data pass through unmodified; no width arithmetic or bounds checking.

Optional Feature:
- Macro: MEM_PORT_ARB_LOCK_EN.
- Defined:
  - In ACK, if req[sel] && lock[sel], the next state is ISSUE rather than IDLE.
  - gnt stays high, and the new fields are sampled at the ACK->ISSUE edge.
  - Back-to-back locked transactions take 3 cycles each.
  - The pointer stays at sel; other requesters wait until lock or req drops.
- Undefined: the lock input is ignored (treated as 0); the port remains for interface stability.

Test Plan:
- Reset: drive rstb=0 then release, req=0 -> all outputs 0 and busy=0 for 10 cycles.
- Single write then read: req[2]=1, we=1, addr=7'h05, wdata=8'hA5. Expect mem_en in cycle T+1 with mem_addr=5, mem_wdata=A5, mem_we=1, and ack[2] at T+3. Then a read of 0x05 -> rdata=8'hA5 with ack[2] at T+3, gnt low at T+4.
- Fairness: all four req held high from reset with distinct addresses -> grant order 0,1,2,3,0,1. Exactly one ack every 4 cycles; no gnt or ack is ever multi-hot.
- Request withdrawal: req[1] dropped in the RESP cycle -> ack[1] still pulses at T+3, then the arbiter returns to IDLE.
- Reset mid-operation: rstb pulsed low during ISSUE -> mem_en and gnt go 0 asynchronously, no ack. The next grant goes to requester 0 when req=4'b1111.
- MEM_PORT_ARB_LOCK_EN:
  - With the macro, req[3]=lock[3]=1 plus req[0]=1 -> three requester-3 transactions, each 3 cycles, gnt[3] continuous. When lock[3] drops, requester 0 is granted next.
  - Without the macro, requester 0 is granted right after the first requester-3 ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-ported AW x DW array among NREQ requesters.
// Optional grant lock (back-to-back transactions for one requester) enabled by defining MEM_PORT_ARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 7,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    input  logic [NREQ-1:0]      lock,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int              SW       = $clog2(NREQ);
    localparam logic [SW:0]     NREQ_W   = (SW+1)'(NREQ);
    localparam logic [SW-1:0]   LAST_RST = SW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   sel, sel_n;
    logic [SW-1:0]   last, last_n;
    logic            op_we, op_we_n;
    logic [NREQ-1:0] gnt_n, ack_n;
    logic [DW-1:0]   rdata_n;
    logic            mem_en_n, mem_we_n;
    logic [AW-1:0]   mem_addr_n;
    logic [DW-1:0]   mem_wdata_n;

    logic [AW-1:0]   addr_a  [NREQ];
    logic [DW-1:0]   wdata_a [NREQ];
    logic [NREQ-1:0] lock_eff;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign addr_a[k]  = addr[k*AW +: AW];
        assign wdata_a[k] = wdata[k*DW +: DW];
    end

`ifdef MEM_PORT_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    logic lock_unused;
    assign lock_unused = ^lock;
    assign lock_eff    = '0;
`endif

    // Rotating priority search: last+1, last+2, ... wrapping modulo NREQ.
    logic            found;
    logic [SW-1:0]   pick;
    logic [SW:0]     cand;

    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last} + (SW+1)'(i);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!found && req[cand[SW-1:0]]) begin
                found = 1'b1;
                pick  = cand[SW-1:0];
            end
        end
    end

    logic            ld;
    logic [SW-1:0]   ld_idx;

    always_comb begin
        state_n     = state;
        sel_n       = sel;
        last_n      = last;
        op_we_n     = op_we;
        gnt_n       = gnt;
        ack_n       = '0;
        rdata_n     = rdata;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        ld          = 1'b0;
        ld_idx      = sel;

        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = ISSUE;
                    sel_n       = pick;
                    last_n      = pick;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    ld          = 1'b1;
                    ld_idx      = pick;
                end
            end
            ISSUE: state_n = RESP;
            RESP: begin
                state_n    = ACK;
                ack_n[sel] = 1'b1;
                if (!op_we) rdata_n = mem_rdata;
            end
            ACK: begin
                // A locked requester keeps the port; the pointer stays put.
                if (req[sel] && lock_eff[sel]) begin
                    state_n = ISSUE;
                    ld      = 1'b1;
                    ld_idx  = sel;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (ld) begin
            mem_en_n    = 1'b1;
            mem_we_n    = we[ld_idx];
            op_we_n     = we[ld_idx];
            mem_addr_n  = addr_a[ld_idx];
            mem_wdata_n = wdata_a[ld_idx];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            sel       <= '0;
            last      <= LAST_RST;
            op_we     <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            last      <= last_n;
            op_we     <= op_we_n;
            gnt       <= gnt_n;
            ack       <= ack_n;
            rdata     <= rdata_n;
            busy      <= (state_n != IDLE);
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin / shadow-memory model. Lock scenario follows MEM_PORT_ARB_LOCK_EN.
module tb_mem_port_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 7;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic [NREQ-1:0]      req, we, lock;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt, ack;
    logic [DW-1:0]        rdata;
    logic                 busy, mem_en, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstb(rstb), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // The shared array: registered read, data valid the cycle after the strobe.
    logic [DW-1:0] mem_arr [128];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    function automatic int rr_pick(logic [3:0] r, int lst);
        int c;
        for (int i = 1; i <= NREQ; i++) begin
            c = (lst + i) % NREQ;
            if (r[c[1:0]]) return c;
        end
        return 0;
    endfunction

    task automatic set_req(int k, logic w, logic [6:0] a, logic [7:0] d);
        req[k] = 1'b1;
        we[k]  = w;
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rstb = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        @(negedge clk);
        checks++;
        if ({gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata} !== 34'd0) begin
            errors++; $display("FAIL reset_hold outputs=%h want 0", {gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata});
        end
        rstb = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata} !== 34'd0) begin
                errors++; $display("FAIL reset_idle cyc=%0d outputs=%h want 0", c, {gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata});
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(2, 1'b1, 7'h05, 8'hA5);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'h05 || mem_wdata !== 8'hA5 || busy !== 1'b1) begin
            errors++; $display("FAIL wr_issue gnt=%b en=%b we=%b a=%h d=%h busy=%b want 0100 1 1 05 a5 1", gnt, mem_en, mem_we, mem_addr, mem_wdata, busy);
        end
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || ack !== 4'b0) begin
            errors++; $display("FAIL wr_resp en=%b ack=%b want 0 0000", mem_en, ack);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100 || gnt !== 4'b0100) begin
            errors++; $display("FAIL wr_ack ack=%b gnt=%b want 0100 0100", ack, gnt);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_done gnt=%b ack=%b busy=%b want 0", gnt, ack, busy);
        end
        set_req(2, 1'b0, 7'h05, 8'h00);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'h05) begin
            errors++; $display("FAIL rd_issue gnt=%b en=%b we=%b a=%h want 0100 1 0 05", gnt, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100 || rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_ack ack=%b rdata=%h want 0100 a5", ack, rdata);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_done gnt=%b busy=%b want 0 0", gnt, busy);
        end
    endtask

    task automatic test_fairness();
        int order[$];
        int ack_cyc[$];
        logic [3:0] prev_gnt;
        rstb = 1'b0; lock = '0; req = '0; we = '0;
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 7'(8'h20 + k), 8'h00);
        @(negedge clk);
        rstb = 1'b1;
        prev_gnt = '0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt) || !$onehot0(ack)) begin
                errors++; $display("FAIL fair_onehot cyc=%0d gnt=%b ack=%b", c, gnt, ack);
            end
            if (prev_gnt == 4'b0 && gnt != 4'b0)
                for (int k = 0; k < NREQ; k++) if (gnt[k]) order.push_back(k);
            if (ack != 4'b0) ack_cyc.push_back(c);
            prev_gnt = gnt;
            if (c == 23) req = '0;
        end
        checks++;
        if (order.size() < 6) begin
            errors++; $display("FAIL fair_count grants=%0d want >=6", order.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (order[i] != i % NREQ) begin
                    errors++; $display("FAIL fair_order idx=%0d got %0d want %0d", i, order[i], i % NREQ);
                end
            end
        end
        checks++;
        if (ack_cyc.size() != 6) begin
            errors++; $display("FAIL fair_acks count=%0d want 6", ack_cyc.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] != 4) begin
                    errors++; $display("FAIL fair_spacing idx=%0d gap=%0d want 4", i, ack_cyc[i] - ack_cyc[i-1]);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_withdrawal();
        do_reset();
        set_req(1, 1'b0, 7'h22, 8'h00);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL wd_gnt gnt=%b want 0010", gnt);
        end
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            errors++; $display("FAIL wd_ack ack=%b want 0010", ack);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL wd_idle gnt=%b ack=%b busy=%b want 0", gnt, ack, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2, 1'b1, 7'h30, 8'h3C);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || gnt !== 4'b0100) begin
            errors++; $display("FAIL rm_issue en=%b gnt=%b want 1 0100", mem_en, gnt);
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
            errors++; $display("FAIL rm_async en=%b gnt=%b busy=%b ack=%b want 0", mem_en, gnt, busy, ack);
        end
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 7'(8'h30 + k), 8'h00);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0 || gnt !== 4'b0) begin
            errors++; $display("FAIL rm_held ack=%b gnt=%b want 0", ack, gnt);
        end
        rstb = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || ack !== 4'b0) begin
            errors++; $display("FAIL rm_regrant gnt=%b ack=%b want 0001 0000", gnt, ack);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lock();
        do_reset();
        set_req(3, 1'b1, 7'h10, 8'h11);
        lock[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++; $display("FAIL lk_first gnt=%b want 1000", gnt);
        end
        set_req(0, 1'b1, 7'h11, 8'h22);
`ifdef MEM_PORT_ARB_LOCK_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b1000 || ack !== ((c % 3 == 2) ? 4'b1000 : 4'b0000) || mem_en !== (c % 3 == 0)) begin
                errors++; $display("FAIL lk_burst cyc=%0d gnt=%b ack=%b en=%b", c, gnt, ack, mem_en);
            end
            if (c == 3) begin
                checks++;
                if (mem_wdata !== 8'h12) begin
                    errors++; $display("FAIL lk_resample wdata=%h want 12", mem_wdata);
                end
            end
            if (c == 2) wdata[3*DW +: DW] = 8'h12;
            if (c == 8) begin lock[3] = 1'b0; req[3] = 1'b0; end
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0) begin
            errors++; $display("FAIL lk_release gnt=%b want 0000", gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL lk_next gnt=%b want 0001", gnt);
        end
`else
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 4'b1000) begin
            errors++; $display("FAIL nolk_ack ack=%b want 1000", ack);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0) begin
            errors++; $display("FAIL nolk_drop gnt=%b want 0000", gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL nolk_next gnt=%b want 0001", gnt);
        end
`endif
        req = '0; lock = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] pend, req_prev, oh;
        logic       f_we [NREQ];
        logic [6:0] f_addr [NREQ];
        logic [7:0] f_data [NREQ];
        logic [7:0] shadow [128];
        bit         valid [128];
        int         last_m, cnt, t_sel;
        bit         active, t_we, t_known, rd_known;
        logic [6:0] t_addr;
        logic [7:0] t_data, model_rdata;
        for (int i = 0; i < 128; i++) begin valid[i] = 1'b0; shadow[i] = '0; end
        for (int k = 0; k < NREQ; k++) begin f_we[k] = 1'b0; f_addr[k] = '0; f_data[k] = '0; end
        do_reset();
        last_m = NREQ - 1; active = 0; cnt = 0; pend = '0; req_prev = '0; oh = '0;
        t_sel = 0; t_we = 0; t_known = 0; rd_known = 0; t_addr = '0; t_data = '0; model_rdata = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt) || !$onehot0(ack)) begin
                errors++; $display("FAIL rnd_onehot cyc=%0d gnt=%b ack=%b", cyc, gnt, ack);
            end
            if (active) begin
                cnt++;
                checks++;
                if (cnt == 1) begin
                    if (mem_en !== 1'b0 || ack !== 4'b0 || gnt !== oh) begin
                        errors++; $display("FAIL rnd_resp cyc=%0d en=%b ack=%b gnt=%b want 0 0000 %b", cyc, mem_en, ack, gnt, oh);
                    end
                end else if (cnt == 2) begin
                    if (ack !== oh || gnt !== oh) begin
                        errors++; $display("FAIL rnd_ack cyc=%0d ack=%b gnt=%b want %b", cyc, ack, gnt, oh);
                    end
                    if (!t_we && t_known) begin
                        checks++;
                        if (rdata !== t_data) begin
                            errors++; $display("FAIL rnd_rdata cyc=%0d got %h want %h", cyc, rdata, t_data);
                        end
                    end
                    if (t_we && rd_known) begin
                        checks++;
                        if (rdata !== model_rdata) begin
                            errors++; $display("FAIL rnd_rdata_hold cyc=%0d got %h want %h", cyc, rdata, model_rdata);
                        end
                    end
                    if (!t_we) begin rd_known = t_known; model_rdata = t_data; end
                    pend[t_sel] = 1'b0;
                end else begin
                    if (gnt !== 4'b0 || ack !== 4'b0) begin
                        errors++; $display("FAIL rnd_end cyc=%0d gnt=%b ack=%b want 0", cyc, gnt, ack);
                    end
                    active = 0;
                end
            end else if (req_prev != 4'b0) begin
                t_sel  = rr_pick(req_prev, last_m);
                last_m = t_sel;
                oh     = 4'(1 << t_sel);
                active = 1; cnt = 0;
                t_we   = f_we[t_sel];
                t_addr = f_addr[t_sel];
                if (t_we) begin
                    t_data = f_data[t_sel]; shadow[t_addr] = t_data; valid[t_addr] = 1'b1; t_known = 1;
                end else begin
                    t_data = shadow[t_addr]; t_known = valid[t_addr];
                end
                checks++;
                if (gnt !== oh || mem_en !== 1'b1 || mem_we !== t_we || mem_addr !== t_addr || (t_we && mem_wdata !== t_data)) begin
                    errors++; $display("FAIL rnd_issue cyc=%0d gnt=%b en=%b we=%b a=%h d=%h want %b 1 %b %h %h", cyc, gnt, mem_en, mem_we, mem_addr, mem_wdata, oh, t_we, t_addr, t_data);
                end
            end else begin
                checks++;
                if (gnt !== 4'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
                    errors++; $display("FAIL rnd_idle cyc=%0d gnt=%b busy=%b en=%b want 0", cyc, gnt, busy, mem_en);
                end
            end
            if (cyc < 270) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!pend[k] && $urandom_range(0, 2) == 0) begin
                        pend[k]   = 1'b1;
                        f_we[k]   = 1'($urandom_range(0, 1));
                        f_addr[k] = 7'(8'h40 + $urandom_range(0, 7));
                        f_data[k] = 8'($urandom);
                        set_req(k, f_we[k], f_addr[k], f_data[k]);
                    end
                end
            end
            req = pend;
            req_prev = pend;
        end
        checks++;
        if (pend !== 4'b0 || active) begin
            errors++; $display("FAIL rnd_drain pending=%b active=%0d want 0", pend, active);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fairness();
        test_withdrawal();
        test_reset_mid();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
